// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, ACK/NACK bit levels and
// the register-pointer width helper.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_WAIT_STOP
   } i2c_tgt_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   // Address width for a memory of 'depth' entries, never narrower than one bit.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/i2c_target_mem_if.sv
// Pad-side I2C lines plus the host-side write-notify and busy signals of the
// I2C register target.
interface i2c_target_mem_if
   import i2c_pkg::*;
#(
   parameter int unsigned DEPTH = 256
);

   localparam int unsigned AW = ptr_w(DEPTH);

   logic          scl_i;
   logic          sda_i;
   logic          sda_oe;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;

   modport slave (
      input  scl_i, sda_i,
      output sda_oe, wr_valid, wr_addr, wr_data, busy
   );

   modport master (
      output scl_i, sda_i,
      input  sda_oe, wr_valid, wr_addr, wr_data, busy
   );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA into the clk domain and detects SCL edges and
// START/STOP conditions; shared by the I2C target and controller.
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_d;
   logic                   sda_d;
   logic                   scl_s;

   // NOTE: sequential state uses non-blocking assignments so every flop in the chain samples the pre-edge value.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_d    <= scl_sync[SYNC_STAGES-1];
         sda_d    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   // SCL must be high on both samples so a coincident SCL edge is never taken as START/STOP.
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_mem.sv
// Oversampling I2C target with an internal register memory, 1- or 2-byte
// auto-incrementing pointer and a host-side write-notify strobe.
module i2c_target_mem
   import i2c_pkg::*;
#(
   parameter logic [6:0]  TGT_ADDR    = 7'h42,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned PTR_BYTES   = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic              clk,
   input logic              resetn,
   i2c_target_mem_if.slave  bus
);

   localparam int unsigned AW = ptr_w(DEPTH);

   localparam logic [3:0] IDLE      = ST_IDLE;
   localparam logic [3:0] ADDR      = ST_ADDR;
   localparam logic [3:0] ADDR_ACK  = ST_ADDR_ACK;
   localparam logic [3:0] PTR       = ST_PTR;
   localparam logic [3:0] PTR_ACK   = ST_PTR_ACK;
   localparam logic [3:0] WDATA     = ST_WDATA;
   localparam logic [3:0] WDATA_ACK = ST_WDATA_ACK;
   localparam logic [3:0] RDATA     = ST_RDATA;
   localparam logic [3:0] RDATA_ACK = ST_RDATA_ACK;
   localparam logic [3:0] WAIT_STOP = ST_WAIT_STOP;

   logic          scl_rise, scl_fall, sda_s, start_det, stop_det;
   logic [3:0]    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          rw;
   logic [AW-1:0] ptr;
   logic [1:0]    ptr_cnt;
   logic [7:0]    mem [DEPTH];
   logic          sda_oe, wr_valid, busy;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   logic [7:0]    rx_byte;
   logic [AW+7:0] ptr_cat;
   logic [AW-1:0] ptr_load;
   logic [AW-1:0] ptr_inc;
   logic          mem_we;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .resetn    (resetn),
      .scl_i     (bus.scl_i),
      .sda_i     (bus.sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .sda_s     (sda_s),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign rx_byte  = {shreg[6:0], sda_s};
   assign ptr_cat  = {ptr, rx_byte};
   // 2-byte pointers shift in MSB first; bits above the memory width fall off.
   assign ptr_load = (PTR_BYTES == 2) ? ptr_cat[AW-1:0] : AW'(rx_byte);
   assign ptr_inc  = ptr + AW'(1);
   assign mem_we   = !stop_det && !start_det && scl_rise &&
                     (state == WDATA) && (bit_cnt == 3'd7);

   // NOTE: the memory is cleared by resetn like any other state, so contents read as zero after a reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
      end else if (mem_we) begin
         mem[ptr] <= rx_byte;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         bit_cnt  <= 3'd0;
         shreg    <= 8'h00;
         rw       <= 1'b0;
         ptr      <= '0;
         ptr_cnt  <= 2'd0;
         sda_oe   <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= 8'h00;
         busy     <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         if (stop_det) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else if (start_det) begin
            state   <= ADDR;
            bit_cnt <= 3'd0;
            sda_oe  <= 1'b0;
         end else if (scl_rise) begin
            case (state)
               ADDR: begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (rx_byte[7:1] == TGT_ADDR) begin
                        state <= ADDR_ACK;
                        rw    <= rx_byte[0];
                        busy  <= 1'b1;
                     end else begin
                        state <= WAIT_STOP;
                        busy  <= 1'b0;
                     end
                  end
               end
               ADDR_ACK: begin
                  bit_cnt <= 3'd0;
                  if (rw) begin
                     state <= RDATA;
                     shreg <= mem[ptr];
                  end else begin
                     state   <= PTR;
                     ptr_cnt <= 2'd0;
                  end
               end
               PTR: begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ptr     <= ptr_load;
                     ptr_cnt <= ptr_cnt + 2'd1;
                     state   <= PTR_ACK;
                  end
               end
               PTR_ACK: state <= (ptr_cnt == 2'(PTR_BYTES)) ? WDATA : PTR;
               WDATA: begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     wr_valid <= 1'b1;
                     wr_addr  <= ptr;
                     wr_data  <= rx_byte;
                     ptr      <= ptr_inc;
                     state    <= WDATA_ACK;
                  end
               end
               WDATA_ACK: state <= WDATA;
               RDATA: begin
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= RDATA_ACK;
               end
               RDATA_ACK: begin
                  ptr <= ptr_inc;
                  if (sda_s == I2C_ACK) begin
                     shreg <= mem[ptr_inc];
                     state <= RDATA;
                  end else begin
                     state <= WAIT_STOP;
                     busy  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            // SDA only changes while SCL is low.
            case (state)
               ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oe <= ~I2C_ACK;
               RDATA:                        sda_oe <= ~shreg[7];
               default:                      sda_oe <= 1'b0;
            endcase
         end
      end
   end

   assign bus.sda_oe   = sda_oe;
   assign bus.wr_valid = wr_valid;
   assign bus.wr_addr  = wr_addr;
   assign bus.wr_data  = wr_data;
   assign bus.busy     = busy;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: a bit-banged I2C master drives two targets (8-bit
// pointer / 256 deep, and 16-bit pointer / 16 deep) on separately gated buses.
module tb_i2c_target_mem;
   import i2c_pkg::*;

   localparam time Q = 50ns;

   logic clk = 1'b0;
   logic resetn;
   logic scl_m, sda_m;
   logic sel;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_ev_t;

   typedef struct {
      bit          use_b;
      logic [15:0] ptr;
      logic [7:0]  d0, d1;
      logic [15:0] a0, a1;
      logic [7:0]  next;
   } vec_t;

   wr_ev_t wq[$];
   logic   oe_seen, busy_seen;

   i2c_target_mem_if #(.DEPTH(256)) bus_a ();
   i2c_target_mem_if #(.DEPTH(16))  bus_b ();

   assign bus_a.scl_i = sel ? 1'b1 : scl_m;
   assign bus_a.sda_i = (sel ? 1'b1 : sda_m) & ~bus_a.sda_oe;
   assign bus_b.scl_i = sel ? scl_m : 1'b1;
   assign bus_b.sda_i = (sel ? sda_m : 1'b1) & ~bus_b.sda_oe;

   wire sda_line  = sel ? bus_b.sda_i  : bus_a.sda_i;
   wire oe_line   = sel ? bus_b.sda_oe : bus_a.sda_oe;
   wire busy_line = sel ? bus_b.busy   : bus_a.busy;

   i2c_target_mem #(.TGT_ADDR(7'h42), .DEPTH(256), .PTR_BYTES(1), .SYNC_STAGES(2)) dut_a (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_a.slave)
   );

   i2c_target_mem #(.TGT_ADDR(7'h42), .DEPTH(16), .PTR_BYTES(2), .SYNC_STAGES(3)) dut_b (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_b.slave)
   );

   always #5ns clk = ~clk;

   always @(negedge clk) begin
      if (bus_a.wr_valid) wq.push_back(wr_ev_t'{addr: 16'(bus_a.wr_addr), data: bus_a.wr_data});
      if (bus_b.wr_valid) wq.push_back(wr_ev_t'{addr: 16'(bus_b.wr_addr), data: bus_b.wr_data});
      if (oe_line)   oe_seen   = 1'b1;
      if (busy_line) busy_seen = 1'b1;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b1; #Q;
      #Q;
   endtask

   task automatic clock_bit(input logic b, output logic r);
      sda_m = b;    #Q;
      scl_m = 1'b1; #Q;
      r = sda_line; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
      clock_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic ack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, r);
         d[i] = r;
      end
      clock_bit(ack, r);
   endtask

   // START, write address, pointer byte(s); every byte must be acknowledged.
   task automatic set_ptr(input logic [15:0] p, input int nbytes, input string tag);
      logic ack;
      i2c_start();
      send_byte(8'h84, ack);
      check({tag, "_addr_ack"}, ack, I2C_ACK);
      if (nbytes == 2) begin
         send_byte(p[15:8], ack);
         check({tag, "_ptrh_ack"}, ack, I2C_ACK);
      end
      send_byte(p[7:0], ack);
      check({tag, "_ptr_ack"}, ack, I2C_ACK);
   endtask

   vec_t vecs[5];

   initial begin
      logic       ack;
      logic [7:0] d;
      int         nb;
      int         k;

      vecs[0] = '{use_b: 1'b0, ptr: 16'h0010, d0: 8'hAA, d1: 8'h55, a0: 16'h0010, a1: 16'h0011, next: 8'h00};
      vecs[1] = '{use_b: 1'b0, ptr: 16'h00FF, d0: 8'h3C, d1: 8'hC3, a0: 16'h00FF, a1: 16'h0000, next: 8'h00};
      vecs[2] = '{use_b: 1'b1, ptr: 16'h000F, d0: 8'h11, d1: 8'h22, a0: 16'h000F, a1: 16'h0000, next: 8'h00};
      vecs[3] = '{use_b: 1'b1, ptr: 16'h1237, d0: 8'h5A, d1: 8'hA5, a0: 16'h0007, a1: 16'h0008, next: 8'h00};
      vecs[4] = '{use_b: 1'b0, ptr: 16'h0080, d0: 8'h00, d1: 8'hFF, a0: 16'h0080, a1: 16'h0081, next: 8'h00};

      resetn = 1'b0;
      scl_m  = 1'b1;
      sda_m  = 1'b1;
      sel    = 1'b0;
      oe_seen   = 1'b0;
      busy_seen = 1'b0;
      #100ns;
      resetn = 1'b1;
      #100ns;

      check("rst_sda_oe_a",   bus_a.sda_oe,   1'b0);
      check("rst_wr_valid_a", bus_a.wr_valid, 1'b0);
      check("rst_wr_addr_a",  bus_a.wr_addr,  8'h00);
      check("rst_wr_data_a",  bus_a.wr_data,  8'h00);
      check("rst_busy_a",     bus_a.busy,     1'b0);
      check("rst_sda_oe_b",   bus_b.sda_oe,   1'b0);
      check("rst_busy_b",     bus_b.busy,     1'b0);

      // Address mismatch: no ACK, no drive, no write, never busy.
      wq.delete();
      oe_seen   = 1'b0;
      busy_seen = 1'b0;
      i2c_start();
      send_byte(8'h86, ack);
      check("nomatch_addr_nack", ack, I2C_NACK);
      send_byte(8'h10, ack);
      check("nomatch_data_nack", ack, I2C_NACK);
      i2c_stop();
      check("nomatch_oe_never",   oe_seen,    1'b0);
      check("nomatch_busy_never", busy_seen,  1'b0);
      check("nomatch_no_write",   wq.size(),  0);

      for (int i = 0; i < 5; i++) begin
         sel = vecs[i].use_b;
         nb  = vecs[i].use_b ? 2 : 1;
         wq.delete();
         set_ptr(vecs[i].ptr, nb, $sformatf("v%0d_wr", i));
         send_byte(vecs[i].d0, ack);
         check($sformatf("v%0d_d0_ack", i), ack, I2C_ACK);
         send_byte(vecs[i].d1, ack);
         check($sformatf("v%0d_d1_ack", i), ack, I2C_ACK);
         check($sformatf("v%0d_busy_mid", i), busy_line, 1'b1);
         i2c_stop();
         check($sformatf("v%0d_busy_after_p", i), busy_line, 1'b0);
         check($sformatf("v%0d_wr_count", i), wq.size(), 2);
         if (wq.size() >= 2) begin
            check($sformatf("v%0d_wr_addr0", i), wq[0].addr, vecs[i].a0);
            check($sformatf("v%0d_wr_data0", i), wq[0].data, vecs[i].d0);
            check($sformatf("v%0d_wr_addr1", i), wq[1].addr, vecs[i].a1);
            check($sformatf("v%0d_wr_data1", i), wq[1].data, vecs[i].d1);
         end

         // Combined pointer write, repeated START, two-byte read.
         set_ptr(vecs[i].ptr, nb, $sformatf("v%0d_rd", i));
         i2c_start();
         send_byte(8'h85, ack);
         check($sformatf("v%0d_rd_addr_ack", i), ack, I2C_ACK);
         recv_byte(I2C_ACK, d);
         check($sformatf("v%0d_rd0", i), d, vecs[i].d0);
         recv_byte(I2C_NACK, d);
         check($sformatf("v%0d_rd1", i), d, vecs[i].d1);
         i2c_stop();

         // Pointer advanced past both bytes and persisted across STOP.
         i2c_start();
         send_byte(8'h85, ack);
         check($sformatf("v%0d_next_ack", i), ack, I2C_ACK);
         recv_byte(I2C_NACK, d);
         check($sformatf("v%0d_next", i), d, vecs[i].next);
         i2c_stop();
         check($sformatf("v%0d_no_rd_write", i), wq.size(), 2);
      end

      // Incomplete data byte aborted by STOP is discarded.
      sel = 1'b0;
      wq.delete();
      set_ptr(16'h0020, 1, "abort");
      clock_bit(1'b1, ack);
      clock_bit(1'b0, ack);
      clock_bit(1'b1, ack);
      clock_bit(1'b0, ack);
      i2c_stop();
      check("abort_no_write", wq.size(), 0);
      set_ptr(16'h0020, 1, "abort_rd");
      i2c_start();
      send_byte(8'h85, ack);
      check("abort_rd_addr_ack", ack, I2C_ACK);
      recv_byte(I2C_NACK, d);
      check("abort_rd_data", d, 8'h00);
      i2c_stop();

      // Reset while the target pulls SDA low for bit 6 of 0xAA.
      set_ptr(16'h0010, 1, "rstmid");
      i2c_start();
      send_byte(8'h85, ack);
      check("rstmid_addr_ack", ack, I2C_ACK);
      clock_bit(1'b1, ack);
      check("rstmid_bit7", ack, 1'b1);
      k = 0;
      while (!bus_a.sda_oe && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("rstmid_driving", bus_a.sda_oe, 1'b1);
      resetn = 1'b0;
      #1ns;
      check("rstmid_oe_released", bus_a.sda_oe, 1'b0);
      check("rstmid_busy_clear",  bus_a.busy,   1'b0);
      scl_m = 1'b1;
      sda_m = 1'b1;
      #100ns;
      resetn = 1'b1;
      #100ns;
      set_ptr(16'h0010, 1, "rstmid_after");
      i2c_start();
      send_byte(8'h85, ack);
      check("rstmid_after_addr_ack", ack, I2C_ACK);
      recv_byte(I2C_NACK, d);
      check("rstmid_mem_cleared", d, 8'h00);
      i2c_stop();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
